// File: rtl/pipeline_fetch_unit.sv
// IF-stage front end: PC owner, single-outstanding imem fetch FSM, prefetch queue
// presenting {pcPlus4, instruction} to IF/ID, with stall, ID redirect and halt handling.
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        endProgram
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_READY, S_WAIT, S_DISCARD, S_HALTED} fetchState_t;

  typedef struct packed {
    logic [31:0] pcPlus4;
    logic [31:0] instr;
  } fetchEntry_t;

  fetchState_t       state, stateNxt;
  logic [31:0]       fetchPc;
  logic              haltSeen;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rdPtr, wrPtr;
  fetchEntry_t       q [QDEPTH];
  logic              push, pop, headHalt;

  // In READY nothing is outstanding, so the space check reduces to count < QDEPTH.
  assign imemReq    = reset && !redirect && (state == S_READY) && !haltSeen &&
                      (count < CW'(QDEPTH));
  assign imemAddr   = {fetchPc[31:2], 2'b00};
  assign instrValid = (count != '0);
  assign instruction = instrValid ? q[rdPtr].instr   : 32'h0;
  assign pcPlus4     = instrValid ? q[rdPtr].pcPlus4 : 32'h0;
  assign headHalt   = (q[rdPtr].instr == HALT_WORD);

  assign push = (state == S_WAIT) && imemValid && !redirect;
  assign pop  = instrValid && !stall && !redirect;

  always_comb begin
    stateNxt = state;
    case (state)
      S_READY:   if (imemReq) stateNxt = S_WAIT;
                 else if (haltSeen) stateNxt = S_HALTED;
      S_WAIT:    if (imemValid) stateNxt = S_READY;
      S_DISCARD: if (imemValid) stateNxt = S_READY;
      S_HALTED:  stateNxt = S_HALTED;
      default:   stateNxt = S_READY;
    endcase
    // A response landing in the redirect cycle is simply dropped; otherwise wait it out.
    if (redirect) begin
      if ((state == S_WAIT || state == S_DISCARD) && !imemValid) stateNxt = S_DISCARD;
      else stateNxt = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_READY;
      fetchPc    <= RESET_PC;
      haltSeen   <= 1'b0;
      count      <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      endProgram <= 1'b0;
    end else begin
      state <= stateNxt;
      if (redirect) begin
        fetchPc  <= redirectPc;
        haltSeen <= 1'b0;
        count    <= '0;
        rdPtr    <= '0;
        wrPtr    <= '0;
      end else begin
        if (imemReq) fetchPc <= fetchPc + 32'd4;
        if (push) begin
          wrPtr <= wrPtr + 1'b1;
          if (imemData == HALT_WORD) haltSeen <= 1'b1;
        end
        if (pop) rdPtr <= rdPtr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (pop && headHalt) endProgram <= 1'b1;
    end
  end

  // fetchPc is already advanced while WAITing, so it is the issued PC + 4.
  always_ff @(posedge clk) begin
    if (push) q[wrPtr] <= '{pcPlus4: fetchPc, instr: imemData};
  end
endmodule
